// File: rtl/secure_tx_channel.sv
// rtl/secure_tx_channel.sv - keyed XOR-masking transmit path with per-channel counters and output FIFO
module secure_tx_channel #(
    parameter int DATA_W = 32,
    parameter int KEY_W  = 128,
    parameter int NUM_CH = 4,
    parameter int CTR_W  = 16,
    parameter int DEPTH  = 4,
    localparam int NW    = KEY_W / DATA_W,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              zeroize,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic [CTR_W-1:0]  out_seq,
    output logic              key_loaded,
    output logic              wiping,
    output logic              key_err,
    output logic [NUM_CH-1:0] exhausted
);
    localparam int KI_W  = (NW > 1) ? $clog2(NW) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CTR_W-1:0] CTR_MAX   = '1;
    localparam logic [KI_W-1:0]  WIPE_LAST = KI_W'(NW - 1);
    localparam logic [PTR_W:0]   FIFO_CAP  = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_NOKEY, ST_READY, ST_WIPE} state_t;

    state_t            state_q, state_d;
    logic [KI_W-1:0]   wipe_idx_q, wipe_idx_d;
    logic              key_err_q, key_err_d;
    logic [DATA_W-1:0] key_q [NW];
    logic [CTR_W-1:0]  ctr_q [NUM_CH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [CH_W-1:0]   ch_mem [DEPTH];
    logic [CTR_W-1:0]  seq_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;

    logic              load_ok, push, pop, fifo_full;
    logic [CTR_W-1:0]  cur_ctr;
    logic [KI_W-1:0]   key_idx;
    logic [DATA_W-1:0] keystream;

    assign load_ok   = (state_q == ST_NOKEY) && key_load && !zeroize;
    assign fifo_full = (count_q == FIFO_CAP);
    assign cur_ctr   = ctr_q[in_ch];
    assign key_idx   = KI_W'(cur_ctr % CTR_W'(NW));
    assign keystream = key_q[key_idx] + DATA_W'(cur_ctr);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            exhausted[i] = (ctr_q[i] == CTR_MAX);
        end
    end

    // Zeroize in the same cycle blocks acceptance so nothing slips past the flush.
    assign in_ready = (state_q == ST_READY) && !fifo_full && !exhausted[in_ch] && !zeroize;
    assign push     = in_valid && in_ready;
    assign out_valid = (count_q != '0);
    assign pop      = out_valid && out_ready;

    assign out_data   = out_valid ? data_mem[rd_ptr_q] : '0;
    assign out_ch     = out_valid ? ch_mem[rd_ptr_q]   : '0;
    assign out_seq    = out_valid ? seq_mem[rd_ptr_q]  : '0;
    assign key_loaded = (state_q == ST_READY);
    assign wiping     = (state_q == ST_WIPE);
    assign key_err    = key_err_q;

    always_comb begin
        state_d    = state_q;
        wipe_idx_d = wipe_idx_q;
        key_err_d  = key_err_q;
        if (zeroize) begin
            state_d    = ST_WIPE;
            wipe_idx_d = '0;
        end else begin
            case (state_q)
                ST_NOKEY: if (key_load) state_d = ST_READY;
                ST_READY: if (key_load) key_err_d = 1'b1;
                ST_WIPE: begin
                    if (key_load) key_err_d = 1'b1;
                    if (wipe_idx_q == WIPE_LAST) begin
                        state_d    = ST_NOKEY;
                        wipe_idx_d = '0;
                    end else begin
                        wipe_idx_d = wipe_idx_q + 1'b1;
                    end
                end
                default: state_d = ST_NOKEY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_NOKEY;
            wipe_idx_q <= '0;
            key_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wipe_idx_q <= wipe_idx_d;
            key_err_q  <= key_err_d;
        end
    end

    // One key word is cleared per WIPE cycle; reset clears the whole register at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NW; i++) key_q[i] <= '0;
        end else if (load_ok) begin
            for (int i = 0; i < NW; i++) key_q[i] <= key_in[i*DATA_W +: DATA_W];
        end else if (state_q == ST_WIPE && !zeroize) begin
            key_q[wipe_idx_q] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || zeroize || load_ok) begin
            for (int i = 0; i < NUM_CH; i++) ctr_q[i] <= '0;
        end else if (push) begin
            ctr_q[in_ch] <= cur_ctr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= in_data ^ keystream;
            ch_mem[wr_ptr_q]   <= in_ch;
            seq_mem[wr_ptr_q]  <= cur_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || zeroize) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_secure_tx_channel.sv
// tb/tb_secure_tx_channel.sv - self-checking bench for secure_tx_channel
module tb_secure_tx_channel;
    localparam int DW = 32, KW = 128, NCH = 4, CW = 4, DEP = 4, NWD = 4;
    localparam logic [KW-1:0] K0 = 128'h00000004_00000003_00000002_00000001;

    logic          clk = 1'b0;
    logic          reset, key_load, zeroize, in_valid, in_ready, out_valid, out_ready;
    logic          key_loaded, wiping, key_err;
    logic [KW-1:0] key_in;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    in_ch, out_ch;
    logic [CW-1:0] out_seq;
    logic [NCH-1:0] exhausted;

    secure_tx_channel #(.DATA_W(DW), .KEY_W(KW), .NUM_CH(NCH), .CTR_W(CW), .DEPTH(DEP)) dut (
        .clk(clk), .reset(reset), .key_load(key_load), .key_in(key_in), .zeroize(zeroize),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .out_seq(out_seq), .key_loaded(key_loaded), .wiping(wiping), .key_err(key_err),
        .exhausted(exhausted)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [DW-1:0] mkey [NWD];

    typedef struct { logic [DW-1:0] din; logic [1:0] ch; logic [DW-1:0] edata; logic [CW-1:0] eseq; } vec_t;
    typedef struct { logic [DW-1:0] d; logic [1:0] ch; int seq; } ent_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mask(input logic [DW-1:0] d, input int c);
        return d ^ (mkey[c % NWD] + DW'(c));
    endfunction

    task automatic setk(input logic [KW-1:0] k);
        for (int i = 0; i < NWD; i++) mkey[i] = k[i*DW +: DW];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; key_load = 0; zeroize = 0; in_valid = 0; out_ready = 0;
        in_data = '0; in_ch = '0; key_in = '0;
        tick(); tick();
        reset = 0;
    endtask

    task automatic load_key(input logic [KW-1:0] k);
        key_in = k; key_load = 1;
        tick();
        key_load = 0;
        setk(k);
    endtask

    task automatic send_one(input string nm, input logic [DW-1:0] d, input logic [1:0] ch,
                            input logic [DW-1:0] ed, input logic [CW-1:0] es);
        out_ready = 1; in_valid = 1; in_data = d; in_ch = ch;
        @(negedge clk);
        chk({nm, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 0;
        @(negedge clk);
        chk({nm, "_out_valid"}, out_valid, 1);
        chk({nm, "_out_data"}, out_data, ed);
        chk({nm, "_out_ch"}, out_ch, ch);
        chk({nm, "_out_seq"}, out_seq, es);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [5];
        logic [DW-1:0] saved [32];
        ent_t q [$];
        int acc, nexp, ms, wl, mctr [NCH];
        bit merr, exp_rdy, acc_b, pop_b;
        logic [DW-1:0] d_s;
        logic [1:0] ch_s;
        logic [NCH-1:0] exp_exh;

        tbl[0] = '{32'hA5A5A5A5, 2'd0, 32'hA5A5A5A4, 4'd0};
        tbl[1] = '{32'h00000000, 2'd0, 32'h00000003, 4'd1};
        tbl[2] = '{32'hFFFFFFFF, 2'd1, 32'hFFFFFFFE, 4'd0};
        tbl[3] = '{32'h00000010, 2'd0, 32'h00000015, 4'd2};
        tbl[4] = '{32'h12345678, 2'd3, 32'h12345679, 4'd0};

        do_reset();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_seq", out_seq, 0);
        chk("rst_key_loaded", key_loaded, 0);
        chk("rst_wiping", wiping, 0);
        chk("rst_key_err", key_err, 0);
        chk("rst_exhausted", exhausted, 0);

        in_valid = 1; in_data = 32'hDEADBEEF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("nokey_in_ready", in_ready, 0);
            chk("nokey_out_valid", out_valid, 0);
            tick();
        end
        in_valid = 0;

        load_key(K0);
        chk("load_key_loaded", key_loaded, 1);
        for (int i = 0; i < 5; i++)
            send_one("basic", tbl[i].din, tbl[i].ch, tbl[i].edata, tbl[i].eseq);
        @(negedge clk);
        chk("basic_drained", out_valid, 0);
        tick();

        key_in = ~K0; key_load = 1;
        tick();
        key_load = 0;
        @(negedge clk);
        chk("keyerr_set", key_err, 1);
        chk("keyerr_still_loaded", key_loaded, 1);
        tick();
        send_one("keyerr_oldkey", 32'h0, 2'd0, 32'h00000007, 4'd3);

        do_reset();
        load_key(K0);
        out_ready = 0; in_valid = 1; in_ch = 2; acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = 32'h100 + i;
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        @(negedge clk);
        chk("bp_accepted", acc, 4);
        chk("bp_ready_low", in_ready, 0);
        tick();
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_seq", out_seq, i);
            chk("bp_out_ch", out_ch, 2);
            chk("bp_out_data", out_data, mask(32'h100 + i, i));
            tick();
        end
        @(negedge clk);
        chk("bp_empty", out_valid, 0);
        tick();

        do_reset();
        load_key(K0);
        out_ready = 1; in_valid = 1; in_ch = 1; acc = 0; nexp = 0;
        for (int i = 0; i < 26; i++) begin
            in_data = $urandom;
            if (i >= 22) in_valid = 0;
            @(negedge clk);
            if (out_valid) begin
                chk("exh_out_seq", out_seq, nexp);
                chk("exh_out_data", out_data, mask(saved[nexp], nexp));
                nexp++;
            end
            if (in_valid && in_ready) begin
                saved[acc] = in_data;
                acc++;
            end
            tick();
        end
        chk("exh_accepted", acc, 15);
        chk("exh_popped", nexp, 15);
        chk("exh_flag", exhausted, 4'b0010);
        in_valid = 1; in_ch = 1;
        @(negedge clk);
        chk("exh_ch1_blocked", in_ready, 0);
        in_ch = 0;
        #1;
        chk("exh_ch0_open", in_ready, 1);
        tick();
        in_valid = 0;
        tick(); tick();

        out_ready = 0; in_valid = 1; in_ch = 0;
        tick(); tick(); tick();
        in_valid = 0;
        @(negedge clk);
        chk("zer_fifo_loaded", out_valid, 1);
        tick();
        zeroize = 1; key_load = 1; key_in = ~K0;
        tick();
        zeroize = 0; key_load = 0; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("zer_wiping", wiping, 1);
            chk("zer_out_valid", out_valid, 0);
            chk("zer_in_ready", in_ready, 0);
            tick();
        end
        @(negedge clk);
        chk("zer_done_wiping", wiping, 0);
        chk("zer_nokey", key_loaded, 0);
        chk("zer_key_err", key_err, 0);
        chk("zer_exhausted", exhausted, 0);
        tick();
        in_valid = 0;
        load_key(K0);
        send_one("zer_reload", 32'hA5A5A5A5, 2'd1, 32'hA5A5A5A4, 4'd0);

        do_reset();
        ms = 0; wl = 0; merr = 0; q.delete();
        for (int i = 0; i < NCH; i++) mctr[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            zeroize   = ($urandom_range(0, 63) == 0);
            key_load  = (ms == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
            key_in    = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = $urandom_range(0, 1) != 0;
            in_ch     = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            out_ready = $urandom_range(0, 3) != 0;
            d_s = in_data; ch_s = in_ch;
            @(negedge clk);
            exp_rdy = (ms == 1) && (q.size() < DEP) && (mctr[ch_s] != 15) && !zeroize;
            for (int i = 0; i < NCH; i++) exp_exh[i] = (mctr[i] == 15);
            chk("rnd_in_ready", in_ready, exp_rdy);
            chk("rnd_out_valid", out_valid, q.size() != 0);
            chk("rnd_key_loaded", key_loaded, ms == 1);
            chk("rnd_wiping", wiping, ms == 2);
            chk("rnd_key_err", key_err, merr);
            chk("rnd_exhausted", exhausted, exp_exh);
            if (q.size() != 0) begin
                chk("rnd_out_data", out_data, q[0].d);
                chk("rnd_out_ch", out_ch, q[0].ch);
                chk("rnd_out_seq", out_seq, q[0].seq);
            end
            acc_b = in_valid && exp_rdy;
            pop_b = out_ready && (q.size() != 0);
            tick();
            if (pop_b) void'(q.pop_front());
            if (acc_b) begin
                q.push_back('{mask(d_s, mctr[ch_s]), ch_s, mctr[ch_s]});
                mctr[ch_s]++;
            end
            if (zeroize) begin
                q.delete();
                for (int i = 0; i < NCH; i++) mctr[i] = 0;
                ms = 2; wl = NWD;
            end else begin
                case (ms)
                    0: if (key_load) begin
                        setk(key_in);
                        for (int i = 0; i < NCH; i++) mctr[i] = 0;
                        ms = 1;
                    end
                    1: if (key_load) merr = 1;
                    default: begin
                        if (key_load) merr = 1;
                        wl--;
                        if (wl == 0) ms = 0;
                    end
                endcase
            end
        end
        zeroize = 0; key_load = 0; in_valid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/secure_tx_channel.md
# secure_tx_channel

Parametrised multi-channel transmit path that never releases payload in cleartext. Each word is XOR-masked with a keystream derived from a write-only session key and a per-channel counter, then queued in an output FIFO under valid/ready handshakes. The block sits between on-chip data producers and the off-chip link serializer. It adds key lifecycle control (load, lock, multi-cycle zeroize) and per-channel counter-exhaustion protection.

## Interface
- DATA_W, 32: payload width; KEY_W must be a multiple of it.
- KEY_W, 128: session key width; NW = KEY_W/DATA_W key words.
- NUM_CH, 4: logical channels; CH_W = clog2(NUM_CH), minimum 1.
- CTR_W, 16: per-channel counter width.
- DEPTH, 4: output FIFO entries; power of 2, at least 2.

Ports (reset is synchronous, active-high; clock is clk):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- key_load  in  1  one-cycle pulse that loads key_in.
- key_in  in  KEY_W  session key; word i = key_in[i*DATA_W +: DATA_W].
- zeroize  in  1  one-cycle pulse that starts the key wipe.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  DATA_W  cleartext word.
- in_ch  in  CH_W  channel tag.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  link consumes the head.
- out_data  out  DATA_W  masked word.
- out_ch  out  CH_W  channel of the head.
- out_seq  out  CTR_W  counter value used to mask the head.
- key_loaded  out  1  high in state READY.
- wiping  out  1  high in state WIPE.
- key_err  out  1  sticky; set by key_load outside state NOKEY.
- exhausted  out  NUM_CH  per-channel counter-exhausted flags.

## Operation
- States:
  - NOKEY (reset state).
  - READY.
  - WIPE.
- Transitions:
  - NOKEY→READY on key_load. The key register captures key_in, and all counters clear to 0.
  - READY→WIPE on zeroize.
  - NOKEY→WIPE on zeroize.
  - WIPE→NOKEY after NW cycles.
- key_load in READY or WIPE is ignored and sets key_err. key_err clears only on reset.
- No output port ever exposes the key register.
- Zeroize and key_load in the same cycle: zeroize wins, and key_err is not set.
- in_ready = (state==READY) && !fifo_full && !exhausted[in_ch] && !zeroize. This is combinational in in_ch. in_ready is never high in NOKEY or WIPE, so cleartext cannot pass unkeyed.
- Accept occurs when in_valid && in_ready. Channel ch uses counter c = ctr[ch] and key word K[c mod NW].
  - ks = (K[c mod NW] + zero-extended c) mod 2^DATA_W.
  - The FIFO pushes {in_data ^ ks, ch, c}.
  - ctr[ch] increments by 1.
- exhausted[ch] = (ctr[ch] == 2^CTR_W−1). That value is never used, so no keystream is reused. A channel stays exhausted until zeroize or reset.
- Pop occurs when out_valid && out_ready. Push and pop may happen in the same cycle. When the FIFO is full, a push is refused even if a pop happens that cycle.
- Zeroize accepted in any state:
  - The FIFO flushes on the next edge (count = 0).
  - All counters clear and all exhausted flags clear.
  - WIPE then writes 0 to key word i on its i-th cycle, for i = 0..NW−1.
- After a wipe completes, the key register holds all zeros.
- Zeroize during WIPE restarts the wipe at word 0.

## Timing
- Reset values:
  - in_ready = 0, out_valid = 0.
  - out_data, out_ch, out_seq = 0.
  - key_loaded = 0, wiping = 0, key_err = 0, exhausted = 0.
  - Key register, all counters and FIFO pointers = 0.
- Latency:
  - A word accepted at edge N is at the FIFO head with out_valid = 1 after edge N if the FIFO was empty.
  - It is otherwise visible after all older entries pop.
- out_data, out_ch and out_seq are registered from the FIFO head. They hold stable while out_valid && !out_ready.
- key_load at edge N: key_loaded = 1 and in_ready can be high from cycle N+1.
- Zeroize at edge N:
  - wiping = 1 and out_valid = 0 from cycle N+1.
  - wiping = 0 and the state is NOKEY from cycle N+1+NW.
- Reset mid-wipe goes straight to NOKEY with the key cleared in one cycle.

## Test plan
- Basic masking. Defaults; load key_in = 128'h00000004_00000003_00000002_00000001. Then send ch0 words 32'hA5A5A5A5 and 32'h00000000. Required: out_data = 32'hA5A5A5A4 with out_seq = 0, then 32'h00000003 with out_seq = 1; out_ch = 0 for both.
- No key. Drive in_valid = 1 after reset with no key loaded. Required: in_ready stays 0 and out_valid stays 0 for 20 cycles.
- Backpressure. With DEPTH = 4 and out_ready = 0, offer 6 words on ch2. Required: exactly 4 are accepted and in_ready then drops. After out_ready = 1, heads pop in order with out_seq 0..3.
- Exhaustion. With CTR_W = 4, stream on ch1. Required: 15 words are accepted (out_seq 0..14), then exhausted[1] = 1. ch0 is still accepted.
- Zeroize. Zeroize is pulsed while the FIFO holds 3 entries and key_load is asserted in the same cycle. Required:
  - out_valid = 0 the next cycle, with wiping = 1 for 4 cycles.
  - The state returns to NOKEY, key_err = 0, and exhausted = 0.
- Key error. A second key_load in READY sets key_err = 1. The original key stays in use, checked against the masking expected from the first test.
